game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Top-level game-flow controller that sits directly upstream of play_screen.
- Debounces the raw board buttons and generates the `state[2:0]` and `dir[1:0]` inputs that play_screen consumes.
- Consumes play_screen's `score`/`miss` outputs and a round timer to decide win/lose.
- Also drives a countdown value for the seven-segment/status display.

Parameters:
- DEB_CYCLES, 20'd1000000, stable cycles before a button change is accepted (10 ms at 100 MHz).
- TICK_CYCLES, 27'd100000000, clk cycles per one-second timer tick.
- ROUND_SECS, 7'd60, round length in seconds.
- WIN_SCORE, 4'd9, score at or above which the round is won.
- MAX_MISS, 4'd5, miss count at or above which the round is lost.

Ports:
- clk, input, 1, system clock (same clock fed to play_screen).
- rst, input, 1, asynchronous active-low reset.
- btn_start, input, 1, raw start/restart button, active-high, asynchronous to clk.
- btn_pause, input, 1, raw pause/resume button, active-high.
- btn_left, input, 1, raw move-left button, active-high.
- btn_right, input, 1, raw move-right button, active-high.
- score, input, 4, current score from play_screen, unsigned.
- miss, input, 4, current miss count from play_screen, unsigned.
- state, output, 3, game state to play_screen.
- dir, output, 2, paddle direction to play_screen.
- time_left, output, 7, seconds remaining in the round.
- round_over, output, 1, high while in WIN or LOSE.

Behaviour:
- Reset (rst low, asynchronous):
  - state=3'b000, dir=2'b00, time_left=ROUND_SECS, round_over=0.
  - All debounce counters, tick counter and edge registers cleared.
- Input synchronisation and debounce (per button):
  - Each button passes through a 2-flop synchroniser, then a debouncer.
  - Debounced level changes only after the synchronised input differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
  - Rising-edge pulse (1 cycle) is produced on the debounced level for btn_start and btn_pause.
  - Press-to-state latency = 2 + DEB_CYCLES + 1 cycles.
- State encoding:
  - IDLE=3'b000, PLAY=3'b010, PAUSE=3'b100, WIN=3'b101, LOSE=3'b111.
  - `state` is registered.
- Transitions, evaluated each clk; priority top to bottom within each state:
  - IDLE: start pulse -> PLAY; time_left reloaded to ROUND_SECS; tick counter cleared.
  - PLAY:
    - score>=WIN_SCORE -> WIN.
    - else miss>=MAX_MISS -> LOSE.
    - else time_left==0 -> LOSE.
    - else pause pulse -> PAUSE.
    - else start pulse -> IDLE (abort).
    - Win takes priority when the score and miss thresholds are hit in the same cycle.
  - PAUSE: pause pulse -> PLAY; start pulse -> IDLE. If both pulse in the same cycle, start wins.
  - WIN / LOSE: start pulse -> IDLE; everything else is ignored.
- Timer:
  - Tick counter runs only in PLAY and wraps at TICK_CYCLES-1.
  - Each wrap decrements time_left if it is nonzero; time_left saturates at 0 and never wraps to 127.
  - In PAUSE the counter and time_left hold.
  - time_left is reloaded to ROUND_SECS on entry to IDLE.
- dir, registered from the debounced levels:
  - Only left held -> 2'b01.
  - Only right held -> 2'b10.
  - Neither or both -> 2'b00.
  - Forced to 2'b00 in every state except PLAY.
- round_over = 1 exactly when state is WIN or LOSE; registered alongside state.
- Arithmetic: score and miss comparisons are unsigned 4-bit. An input score that has wrapped past 15 is not corrected here.
- Reset mid-round returns to IDLE immediately, with no transition through WIN or LOSE.

Test Plan (bench overrides: DEB_CYCLES=4, TICK_CYCLES=10, ROUND_SECS=3, WIN_SCORE=3, MAX_MISS=2):
- Reset, then hold btn_start for 10 cycles -> state goes 000->010 at cycle 2+4+1 after the press; time_left=3; dir=00.
- In PLAY, pulse btn_start for 2 cycles (shorter than the debounce) -> no state change. A 1-0-1-1-1-1-1 bounce pattern -> PAUSE is not entered until 4 stable cycles, then the action applies.
- In PLAY, hold btn_left -> dir=01; add btn_right -> dir=00; press btn_pause -> state=100, dir=00, and time_left is frozen across 50 cycles.
- In PLAY with score=0, miss=0 -> time_left steps 3,2,1,0 every 10 cycles, then state=111 and round_over=1; a later btn_start -> state=000, time_left=3.
- In PLAY, drive score=3 and miss=2 in the same cycle -> state=101 next cycle.
- Assert rst low asynchronously while in PAUSE with time_left=1 -> outputs reach reset values without waiting for a clk edge.

Source files
------------

// File: rtl/game_ctrl.sv
// Game-flow controller upstream of play_screen: debounces the board buttons,
// runs the round FSM and one-second countdown, and drives state/dir/time_left.
module game_ctrl #(
  parameter logic [19:0] DEB_CYCLES  = 20'd1000000,
  parameter logic [26:0] TICK_CYCLES = 27'd100000000,
  parameter logic [6:0]  ROUND_SECS  = 7'd60,
  parameter logic [3:0]  WIN_SCORE   = 4'd9,
  parameter logic [3:0]  MAX_MISS    = 4'd5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [3:0] score,
  input  logic [3:0] miss,
  output logic [2:0] state,
  output logic [1:0] dir,
  output logic [6:0] time_left,
  output logic       round_over
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    PLAY  = 3'b010,
    PAUSE = 3'b100,
    WIN   = 3'b101,
    LOSE  = 3'b111
  } state_t;

  // Button bit order: 0 start, 1 pause, 2 left, 3 right.
  logic [3:0]  btn_raw;
  logic [3:0]  sync_a;
  logic [3:0]  sync_b;
  logic [3:0]  deb;
  logic [1:0]  deb_q;
  logic [19:0] deb_cnt [4];

  logic        start_pulse;
  logic        pause_pulse;
  logic [1:0]  dir_sel;
  logic [26:0] tick_cnt;
  state_t      cur;
  state_t      nxt;

  assign btn_raw = {btn_right, btn_left, btn_pause, btn_start};

  // Two-flop synchroniser, then a level accepted only after DEB_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
      deb    <= '0;
      deb_q  <= '0;
      // NOTE: deb_cnt is a small flop array, not a RAM, so it is reset like any register.
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync_b take the old sync_a, giving two real stages.
      sync_a <= btn_raw;
      sync_b <= sync_a;
      deb_q  <= deb[1:0];
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_CYCLES - 20'd1) begin
          deb[i]     <= sync_b[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 20'd1;
        end
      end
    end
  end

  assign start_pulse = deb[0] & ~deb_q[0];
  assign pause_pulse = deb[1] & ~deb_q[1];

  always_comb begin
    dir_sel = 2'b00;
    if (deb[2] && !deb[3])      dir_sel = 2'b01;
    else if (deb[3] && !deb[2]) dir_sel = 2'b10;
  end

  always_comb begin
    // NOTE: defaulting nxt before the case keeps every path assigned, so no latch is inferred.
    nxt = cur;
    unique case (cur)
      IDLE: if (start_pulse) nxt = PLAY;
      PLAY: begin
        if (score >= WIN_SCORE)     nxt = WIN;
        else if (miss >= MAX_MISS)  nxt = LOSE;
        else if (time_left == 7'd0) nxt = LOSE;
        else if (pause_pulse)       nxt = PAUSE;
        else if (start_pulse)       nxt = IDLE;
      end
      PAUSE: begin
        if (start_pulse)      nxt = IDLE;
        else if (pause_pulse) nxt = PLAY;
      end
      WIN, LOSE: if (start_pulse) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State, timer and the play_screen-facing outputs all register together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur        <= IDLE;
      dir        <= 2'b00;
      round_over <= 1'b0;
      time_left  <= ROUND_SECS;
      tick_cnt   <= '0;
    end else begin
      cur        <= nxt;
      dir        <= (nxt == PLAY) ? dir_sel : 2'b00;
      round_over <= (nxt == WIN) || (nxt == LOSE);
      if (nxt == IDLE) begin
        time_left <= ROUND_SECS;
        tick_cnt  <= '0;
      end else if (cur == PLAY) begin
        if (tick_cnt == TICK_CYCLES - 27'd1) begin
          tick_cnt <= '0;
          if (time_left != 7'd0) time_left <= time_left - 7'd1;
        end else begin
          tick_cnt <= tick_cnt + 27'd1;
        end
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised and directed bench for game_ctrl against a behavioural model
// built from button sample history and elapsed play time.
module tb_game_ctrl;

  localparam int DEB  = 4;
  localparam int TICK = 10;
  localparam int SECS = 3;
  localparam int WINS = 3;
  localparam int MAXM = 2;

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_PLAY  = 3'b010;
  localparam logic [2:0] S_PAUSE = 3'b100;
  localparam logic [2:0] S_WIN   = 3'b101;
  localparam logic [2:0] S_LOSE  = 3'b111;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_left  = 1'b0;
  logic       btn_right = 1'b0;
  logic [3:0] score = 4'd0;
  logic [3:0] miss  = 4'd0;
  logic [2:0] state;
  logic [1:0] dir;
  logic [6:0] time_left;
  logic       round_over;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  game_ctrl #(
    .DEB_CYCLES (20'd4),
    .TICK_CYCLES(27'd10),
    .ROUND_SECS (7'd3),
    .WIN_SCORE  (4'd3),
    .MAX_MISS   (4'd2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .score     (score),
    .miss      (miss),
    .state     (state),
    .dir       (dir),
    .time_left (time_left),
    .round_over(round_over)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0]     m_state      = S_IDLE;
  logic [1:0]     m_dir        = 2'b00;
  logic           m_round_over = 1'b0;
  int             m_play_cycles = 0;
  logic [3:0]     m_deb        = '0;
  logic [3:0]     m_deb_prev   = '0;
  logic [DEB+1:0] m_hist [4]   = '{default: '0};

  // Seconds left follow directly from the number of clock cycles spent in PLAY.
  function automatic int m_time_left();
    int secs;
    secs = m_play_cycles / TICK;
    return (secs >= SECS) ? 0 : SECS - secs;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic [3:0] raw;
    logic       sp, pp;
    logic [2:0] nxt;
    int         tl;
    if (!rst) begin
      m_state       = S_IDLE;
      m_dir         = 2'b00;
      m_round_over  = 1'b0;
      m_play_cycles = 0;
      m_deb         = '0;
      m_deb_prev    = '0;
      for (int b = 0; b < 4; b++) m_hist[b] = '0;
    end else begin
      raw = {btn_right, btn_left, btn_pause, btn_start};
      sp  = m_deb[0] & ~m_deb_prev[0];
      pp  = m_deb[1] & ~m_deb_prev[1];
      tl  = m_time_left();
      nxt = m_state;
      case (m_state)
        S_IDLE:  if (sp) nxt = S_PLAY;
        S_PLAY: begin
          if (int'(score) >= WINS)     nxt = S_WIN;
          else if (int'(miss) >= MAXM) nxt = S_LOSE;
          else if (tl == 0)            nxt = S_LOSE;
          else if (pp)                 nxt = S_PAUSE;
          else if (sp)                 nxt = S_IDLE;
        end
        S_PAUSE: if (sp) nxt = S_IDLE; else if (pp) nxt = S_PLAY;
        default: if (sp) nxt = S_IDLE;
      endcase
      if (nxt == S_IDLE)         m_play_cycles = 0;
      else if (m_state == S_PLAY) m_play_cycles++;
      if (nxt == S_PLAY)
        m_dir = (m_deb[2] && !m_deb[3]) ? 2'b01 : (m_deb[3] && !m_deb[2]) ? 2'b10 : 2'b00;
      else
        m_dir = 2'b00;
      m_round_over = (nxt == S_WIN) || (nxt == S_LOSE);
      m_state      = nxt;
      m_deb_prev   = m_deb;
      // A level is accepted once the last DEB synchronised samples (two cycles old) all oppose it.
      for (int b = 0; b < 4; b++) begin
        m_hist[b] = {m_hist[b][DEB:0], raw[b]};
        if (m_hist[b][DEB+1:2] == {DEB{~m_deb[b]}}) m_deb[b] = ~m_deb[b];
      end
    end
  end

  always @(negedge clk) begin
    check("state", state, m_state);
    check("dir", dir, m_dir);
    check("time_left", time_left, m_time_left());
    check("round_over", round_over, m_round_over);
  end

  task automatic check_reset_values(input string tag);
    check({tag, " state"}, state, S_IDLE);
    check({tag, " dir"}, dir, 2'b00);
    check({tag, " time_left"}, time_left, SECS);
    check({tag, " round_over"}, round_over, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);

    // Round 1: start latency, short glitch, timer expiry, restart.
    for (int e = 1; e <= 60; e++) begin
      btn_start = (e <= 10) || (e == 20) || (e == 21) || (e >= 41 && e <= 45);
      @(negedge clk);
      case (e)
        6:  check("start latency pre", state, S_IDLE);
        7:  begin
              check("start latency", state, S_PLAY);
              check("play time_left", time_left, 3);
              check("play dir", dir, 2'b00);
            end
        16: check("tick before wrap", time_left, 3);
        17: check("first tick", time_left, 2);
        30: check("glitch ignored", state, S_PLAY);
        37: check("time_left zero", time_left, 0);
        38: begin
              check("timeout lose", state, S_LOSE);
              check("lose round_over", round_over, 1'b1);
            end
        46: check("lose holds", state, S_LOSE);
        47: begin
              check("restart idle", state, S_IDLE);
              check("idle reload", time_left, 3);
            end
        default: ;
      endcase
    end

    // Round 2: direction, bouncing pause, freeze, resume, pause at time_left=1.
    for (int e = 1; e <= 95; e++) begin
      btn_start = (e <= 5);
      btn_left  = (e >= 3 && e <= 40);
      btn_right = (e >= 10 && e <= 40);
      btn_pause = (e == 17) || (e >= 19 && e <= 26) || (e >= 76 && e <= 80) || (e >= 87 && e <= 91);
      @(negedge clk);
      case (e)
        9:  check("dir left", dir, 2'b01);
        15: check("dir left only", dir, 2'b01);
        16: check("dir both", dir, 2'b00);
        24: check("bounce holds play", state, S_PLAY);
        25: begin
              check("pause entered", state, S_PAUSE);
              check("pause dir", dir, 2'b00);
              check("pause time_left", time_left, 2);
            end
        75: begin
              check("pause frozen state", state, S_PAUSE);
              check("pause frozen time", time_left, 2);
            end
        82: check("resume", state, S_PLAY);
        84: check("resume tick", time_left, 1);
        93: begin
              check("second pause", state, S_PAUSE);
              check("second pause time", time_left, 1);
            end
        default: ;
      endcase
    end

    // Asynchronous reset mid-cycle while paused.
    #2 rst = 1'b0;
    #1 check_reset_values("async reset");
    btn_left = 1'b0; btn_right = 1'b0; btn_pause = 1'b0; btn_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Round 3: score and miss thresholds hit together -> WIN.
    for (int e = 1; e <= 20; e++) begin
      btn_start = (e <= 5) || (e >= 13 && e <= 17);
      score     = (e >= 10) ? 4'd3 : 4'd0;
      miss      = (e >= 10) ? 4'd2 : 4'd0;
      @(negedge clk);
      case (e)
        9:  check("before win", state, S_PLAY);
        10: begin
              check("win priority", state, S_WIN);
              check("win round_over", round_over, 1'b1);
            end
        19: begin
              check("win restart", state, S_IDLE);
              check("idle round_over", round_over, 1'b0);
            end
        default: ;
      endcase
    end
    score = 4'd0;
    miss  = 4'd0;

    // Randomised phase, checked every cycle against the model.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 11) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 7) == 0)  btn_pause = ~btn_pause;
      if ($urandom_range(0, 4) == 0)  btn_left  = ~btn_left;
      if ($urandom_range(0, 4) == 0)  btn_right = ~btn_right;
      if ($urandom_range(0, 15) == 0)
        score = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0)
        miss = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
